// File: rtl/rx_ltssm_substate_monitor_if.sv
// rx_ltssm_substate_monitor_if: LTSSM-side request/report bus for the RX substate monitor.
// Optional fail status signals exist when RX_LTSSM_FAIL_STATUS_EN is defined.
interface rx_ltssm_substate_monitor_if #(
    parameter int MAXLANES = 16
);
    logic [3:0]          substate;
    logic                rearm;
    logic                force_detect;
    logic [MAXLANES-1:0] active_lanes;
    logic [MAXLANES-1:0] os_match;
    logic                rx_eidle_exit;
    logic                finish;
    logic [3:0]          exit_to;
    logic [MAXLANES-1:0] os_checker_en;
    logic [4:0]          required_count;
    logic                disable_descrambler;
    logic                busy;
`ifdef RX_LTSSM_FAIL_STATUS_EN
    logic [7:0]          fail_count;
    logic [MAXLANES-1:0] fail_lanes;
`endif

    modport master (
        output substate, rearm, force_detect, active_lanes, os_match, rx_eidle_exit,
        input  finish, exit_to, os_checker_en, required_count, disable_descrambler, busy
`ifdef RX_LTSSM_FAIL_STATUS_EN
        , input fail_count, fail_lanes
`endif
    );

    modport slave (
        input  substate, rearm, force_detect, active_lanes, os_match, rx_eidle_exit,
        output finish, exit_to, os_checker_en, required_count, disable_descrambler, busy
`ifdef RX_LTSSM_FAIL_STATUS_EN
        , output fail_count, fail_lanes
`endif
    );
endinterface

// File: rtl/rx_ltssm_substate_monitor.sv
// rx_ltssm_substate_monitor: arms per-lane OS checkers for an LTSSM substate and judges success/timeout.
// Define RX_LTSSM_FAIL_STATUS_EN to add fail_count/fail_lanes status outputs.
module rx_ltssm_substate_monitor #(
    parameter int MAXLANES     = 16,
    parameter int TICKS_PER_MS = 250000,
    parameter int MS_W         = 6
) (
    input logic clk,
    input logic reset,
    rx_ltssm_substate_monitor_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COUNT   = 2'd1;
    localparam logic [1:0] SUCCESS = 2'd2;
    localparam logic [1:0] FAIL    = 2'd3;
    localparam int PRE_W = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICKS_PER_MS - 1);

    logic [1:0]      state;
    logic [3:0]      latched;
    logic [3:0]      lastSubstate;
    logic [3:0]      exitReg;
    logic            forced;
    logic            disReg;
    logic [MS_W-1:0] msCnt;
    logic [PRE_W-1:0] preCnt;
    logic [4:0]      reqCount;
    logic            lanesOk;
    logic            timeoutNow;
    logic            successNow;
    logic            accept;
    logic            finishNow;
    logic [3:0]      nextExit;

    function automatic logic [4:0] countFor(input logic [3:0] s);
        return (s == 4'd0 || s == 4'd1) ? 5'd0 :
               (s == 4'd2 || s == 4'd3 || s == 4'd8 || s == 4'd9) ? 5'd8 : 5'd2;
    endfunction

    function automatic logic [MS_W-1:0] msFor(input logic [3:0] s);
        return s == 4'd0 ? MS_W'(12) :
               s == 4'd1 ? MS_W'(0) :
               s == 4'd3 ? MS_W'(48) :
               (s == 4'd6 || s == 4'd9) ? MS_W'(2) : MS_W'(24);
    endfunction

    // Decode success/timeout and build the outputs that must be valid in the finish cycle itself.
    always_comb begin
        lanesOk    = (|bus.active_lanes) && ((bus.os_match & bus.active_lanes) == bus.active_lanes);
        timeoutNow = (preCnt == '0) && (msCnt == MS_W'(1));
        successNow = latched == 4'd0 ? (bus.rx_eidle_exit || timeoutNow) :
                     latched == 4'd1 ? 1'b1 : lanesOk;
        accept     = (state == IDLE) && !bus.rearm && (bus.substate <= 4'd9) && (bus.substate != lastSubstate);
        finishNow  = (state == SUCCESS || state == FAIL) && !bus.force_detect;
        nextExit   = state == FAIL ? 4'd0 : forced ? 4'd1 : latched + 4'd1;
        bus.finish              = finishNow;
        bus.exit_to             = finishNow ? nextExit : exitReg;
        bus.disable_descrambler = (finishNow && state == SUCCESS && latched == 4'd9 && !forced) ? 1'b0 : disReg;
        bus.os_checker_en       = state == COUNT ? bus.active_lanes : '0;
        bus.required_count      = reqCount;
        bus.busy                = state != IDLE;
    end

    // Main FSM with ms prescaler; force_detect overrides everything but reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            latched      <= 4'd0;
            lastSubstate <= 4'hF;
            forced       <= 1'b0;
            exitReg      <= 4'd0;
            disReg       <= 1'b1;
            msCnt        <= '0;
            preCnt       <= '0;
            reqCount     <= 5'd0;
        end else if (bus.force_detect) begin
            state    <= COUNT;
            latched  <= 4'd0;
            forced   <= 1'b1;
            msCnt    <= msFor(4'd0);
            preCnt   <= PRE_TOP;
            reqCount <= countFor(4'd0);
            disReg   <= 1'b1;
        end else if (state == IDLE) begin
            if (bus.rearm) begin
                lastSubstate <= 4'hF;
            end else if (accept) begin
                state    <= COUNT;
                latched  <= bus.substate;
                msCnt    <= msFor(bus.substate);
                preCnt   <= PRE_TOP;
                reqCount <= countFor(bus.substate);
                disReg   <= 1'b1;
            end
        end else if (state == COUNT) begin
            if (preCnt == '0) begin
                preCnt <= PRE_TOP;
                msCnt  <= msCnt - MS_W'(1);
            end else begin
                preCnt <= preCnt - PRE_W'(1);
            end
            if (successNow) begin
                state <= SUCCESS;
            end else if (timeoutNow) begin
                state <= FAIL;
            end
        end else begin
            state        <= IDLE;
            forced       <= 1'b0;
            lastSubstate <= latched;
            exitReg      <= nextExit;
            if (state == SUCCESS && latched == 4'd9 && !forced) begin
                disReg <= 1'b0;
            end
        end
    end

`ifdef RX_LTSSM_FAIL_STATUS_EN
    logic [7:0]          failCnt;
    logic [MAXLANES-1:0] failLanes;

    // Saturating FAIL counter and snapshot of the lanes that never matched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            failCnt   <= 8'd0;
            failLanes <= '0;
        end else if (finishNow && state == FAIL) begin
            failCnt   <= failCnt == 8'hFF ? failCnt : failCnt + 8'd1;
            failLanes <= bus.active_lanes & ~bus.os_match;
        end
    end

    assign bus.fail_count = failCnt;
    assign bus.fail_lanes = failLanes;
`endif
endmodule
